zap_shift_arbiter: RTL and testbench
====================================

# zap_shift_arbiter

Shares one barrel shifter between two requesters: port 0 (ALU operand path) and port 1 (load/store register-offset path). Accepts one shift request per cycle and issues it to a single `zap_shift_shifter` instance. Resolves the final carry and registers the result into a one-entry output stage with valid/ready backpressure. Port 0 has default priority; a starvation counter guarantees port 1 forward progress.

## Interface
- `SHIFT_OPS`, 5: number of shift encodings; sets the `i_shift_type_*` width.
- `STARVE_LIMIT`, 4: consecutive port-0 wins, with port 1 waiting, before port 1 is forced; legal range 1..15.
- `i_clk`  in  1  single clock; all state changes on its rising edge.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_flush`  in  1  pipeline flush; discards the output entry and clears the starvation counter.
- `i_valid_0` / `i_valid_1`  in  1  request valid per port.
- `i_source_0` / `i_source_1`  in  32  operand to shift.
- `i_amount_0` / `i_amount_1`  in  8  shift amount.
- `i_shift_type_0` / `i_shift_type_1`  in  `$clog2(SHIFT_OPS)`  LSL/LSR/ASR/ROR/RORI, encoded per the shared shift-type constants.
- `i_carry_0` / `i_carry_1`  in  1  current CPSR carry for that request.
- `o_ready_0` / `o_ready_1`  out  1  grant; a request is accepted when valid and ready are both high in the same cycle.
- `o_valid`  out  1  output entry holds a result.
- `i_out_ready`  in  1  consumer accepts the entry.
- `o_tag`  out  1  port that issued the entry.
- `o_result`  out  32  shifted value.
- `o_carry`  out  1  resolved shifter carry-out.

## Operation
- State machine states:
  - EMPTY: `o_valid` = 0.
  - FULL: `o_valid` = 1.
- Slot-free condition: state is EMPTY, or state is FULL with `i_out_ready` = 1 (drain and refill in the same cycle).
- Grant, evaluated combinationally and only when the slot is free and `i_flush` = 0:
  - Only port 0 valid: grant 0.
  - Only port 1 valid: grant 1.
  - Both valid: grant 1 when `starve_cnt` == `STARVE_LIMIT`, else grant 0.
  - At most one `o_ready_*` is high in any cycle.
  - Ready is a function of the slot, flush and starve state only. It does not depend on the granted port's own valid, except for the both-valid tie-break.
- Shifter input is muxed from the granted port. Port 0 is selected when nothing is granted.
- Carry resolution: `o_carry` = shifter use-old-carry flag ? the granted port's `i_carry_*` : shifter carry-out. This is captured at accept.
- `starve_cnt`, 4 bits:
  - Increments on a cycle where port 0 is accepted while `i_valid_1` = 1.
  - Clears on any port-1 accept.
  - Otherwise holds.
  - Never exceeds `STARVE_LIMIT`.
- Transitions:
  - EMPTY → FULL on accept.
  - FULL → EMPTY on drain with no accept.
  - FULL → FULL on drain with accept; the new payload is loaded.
  - FULL → FULL on stall; payload held.
- Flush has priority over everything except reset:
  - Next state is EMPTY, `starve_cnt` is cleared, and there is no accept that cycle.
  - An entry presented with `i_out_ready` = 1 in the flush cycle is still considered consumed.
- Requesters must hold their payload stable while valid and not ready. The arbiter does not sample a payload until it grants.

## Timing
- Reset values: state EMPTY, `o_valid` 0, `o_tag` 0, `o_result` 0x00000000, `o_carry` 0, `starve_cnt` 0.
- `o_ready_*` is 0 during any cycle where `i_reset` = 1.
- Latency: accept in cycle N gives `o_valid`/`o_result` in cycle N+1.
- Throughput: one result per cycle with `i_out_ready` held high.
- Stall: while FULL and `i_out_ready` = 0, all `o_*` payload outputs are bit-stable and both readies are 0.
- Reset asserted mid-stall drops the entry. Outputs take their reset values in the cycle after the reset edge.
- The shifter path is combinational within the accept cycle. It is the critical path: mux → shift → carry-resolve → output flop.

## Structure
- Shared package/include: shift-type constants (LSL, LSR, ASR, ROR, RORI), already used by the shifter.
- New constant added to the package: tag encodings `TAG_ALU` = 0 and `TAG_LSU` = 1.
- One sub-module: `zap_shift_shifter`, instantiated once, with `SHIFT_OPS` passed through.
- Arbiter, counter, FSM and output register live in this block: no further sub-modules.

## Test plan
- Port 0 LSL: source 0x00000001, amount 4, carry 0, `i_out_ready` = 1 → next cycle `o_valid` = 1, `o_tag` = 0, `o_result` = 0x00000010, `o_carry` = 0.
- Port 1 LSR by 0: source 0x80000001, carry-in 1 → `o_result` = 0x80000001, `o_carry` = 1 (old carry used), `o_tag` = 1.
- Both ports valid continuously, `STARVE_LIMIT` = 4, `i_out_ready` = 1 → grant sequence 0,0,0,0,1,0,0,0,0,1; `starve_cnt` peaks at 4.
- Backpressure: accept a port-0 ROR of 0x0000000F by 4 (result 0xF0000000), then hold `i_out_ready` = 0 for 3 cycles → result held stable, both readies 0. Release → drained, and a pending request is accepted in the same cycle.
- `i_flush` while FULL and stalled with port 1 waiting → next cycle `o_valid` = 0, `starve_cnt` = 0, no grant in the flush cycle.
- `i_reset` pulsed while FULL → `o_valid` = 0 and `o_result` = 0 the next cycle; the first request after reset is accepted normally.

Source files
------------

// File: rtl/zap_shift_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// zap_shift_arbiter_pkg
//   Shared constants and types for the shift arbiter and its barrel shifter.
//   - Shift-type encodings (LSL, LSR, ASR, ROR, RORI) used by the shifter.
//   - Output tag encodings identifying the issuing port.
//   - Output-stage FSM state and payload types.
//   - ror32(): 32-bit rotate-right helper.
// ---------------------------------------------------------------------------
package zap_shift_arbiter_pkg;

    // Shift-type encodings.
    localparam int LSL  = 0;
    localparam int LSR  = 1;
    localparam int ASR  = 2;
    localparam int ROR  = 3;
    localparam int RORI = 4;

    // Issuing-port tags carried with each result.
    localparam logic TAG_ALU = 1'b0;
    localparam logic TAG_LSU = 1'b1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    typedef struct packed {
        logic        tag;
        logic [31:0] result;
        logic        carry;
    } out_entry_t;

    // Rotate right by 0..31. A zero amount yields v unchanged, because the
    // left shift by 32 produces zero.
    function automatic logic [31:0] ror32(input logic [31:0] v, input logic [4:0] amt);
        ror32 = (v >> amt) | (v << (6'd32 - {1'b0, amt}));
    endfunction

endpackage

// File: rtl/zap_shift_arbiter_if.sv
// ---------------------------------------------------------------------------
// zap_shift_arbiter_if
//   Request and result bus of the shift arbiter.
//   Ports (per requester 0 = ALU, 1 = LSU):
//     i_valid_*, i_source_*, i_amount_*, i_shift_type_*, i_carry_*  request
//     o_ready_*                                                   grant
//   Result stage:
//     o_valid, o_tag, o_result, o_carry                           entry
//     i_out_ready                                                 consumer ready
//   Modports: slave (the arbiter), master (requesters and consumer).
// ---------------------------------------------------------------------------
interface zap_shift_arbiter_if #(
    parameter int SHIFT_OPS = 5
);
    localparam int TW = $clog2(SHIFT_OPS);

    logic          i_valid_0;
    logic [31:0]   i_source_0;
    logic [7:0]    i_amount_0;
    logic [TW-1:0] i_shift_type_0;
    logic          i_carry_0;
    logic          o_ready_0;

    logic          i_valid_1;
    logic [31:0]   i_source_1;
    logic [7:0]    i_amount_1;
    logic [TW-1:0] i_shift_type_1;
    logic          i_carry_1;
    logic          o_ready_1;

    logic          o_valid;
    logic          i_out_ready;
    logic          o_tag;
    logic [31:0]   o_result;
    logic          o_carry;

    modport slave (
        input  i_valid_0, i_source_0, i_amount_0, i_shift_type_0, i_carry_0,
        input  i_valid_1, i_source_1, i_amount_1, i_shift_type_1, i_carry_1,
        input  i_out_ready,
        output o_ready_0, o_ready_1,
        output o_valid, o_tag, o_result, o_carry
    );

    modport master (
        output i_valid_0, i_source_0, i_amount_0, i_shift_type_0, i_carry_0,
        output i_valid_1, i_source_1, i_amount_1, i_shift_type_1, i_carry_1,
        output i_out_ready,
        input  o_ready_0, o_ready_1,
        input  o_valid, o_tag, o_result, o_carry
    );

endinterface

// File: rtl/zap_shift_shifter.sv
// ---------------------------------------------------------------------------
// zap_shift_shifter
//   Combinational 32-bit barrel shifter with register-shift carry semantics.
//   Ports:
//     i_source         operand
//     i_amount         8-bit shift amount
//     i_shift_type     LSL/LSR/ASR/ROR/RORI encoding
//     o_result         shifted value
//     o_carry          shifter carry-out
//     o_use_old_carry  1 when the caller's existing carry must be kept
//   Behaviour:
//     LSL/LSR/ASR/ROR: amount 0 keeps the operand and the old carry.
//       LSL/LSR by 32 give 0 with carry = the last bit shifted out; by more
//       than 32 give 0 with carry 0. ASR by 32 or more fills with the sign bit.
//       ROR by a non-zero multiple of 32 keeps the operand, carry = bit 31.
//     RORI: rotate by amount[4:0]; a zero rotation keeps the old carry.
//     Unknown encodings pass the operand through with the old carry.
// ---------------------------------------------------------------------------
module zap_shift_shifter
    import zap_shift_arbiter_pkg::*;
#(
    parameter int SHIFT_OPS = 5
) (
    input  logic [31:0]                  i_source,
    input  logic [7:0]                   i_amount,
    input  logic [$clog2(SHIFT_OPS)-1:0] i_shift_type,
    output logic [31:0]                  o_result,
    output logic                         o_carry,
    output logic                         o_use_old_carry
);

    localparam int TW = $clog2(SHIFT_OPS);

    localparam logic [TW-1:0] SH_LSL  = TW'(LSL);
    localparam logic [TW-1:0] SH_LSR  = TW'(LSR);
    localparam logic [TW-1:0] SH_ASR  = TW'(ASR);
    localparam logic [TW-1:0] SH_ROR  = TW'(ROR);
    localparam logic [TW-1:0] SH_RORI = TW'(RORI);

    // One extra bit on the shifted-out side catches the carry directly,
    // including the amount == 32 and amount > 32 corner cases.
    logic [32:0]        lsl_ext;
    logic [32:0]        lsr_ext;
    logic signed [32:0] asr_in;
    logic signed [32:0] asr_ext;
    logic [31:0]        ror_res;
    logic               amount_zero;
    logic               rot_zero;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        o_result        = i_source;
        o_carry         = 1'b0;
        o_use_old_carry = 1'b1;

        lsl_ext     = {1'b0, i_source} << i_amount;
        lsr_ext     = {i_source, 1'b0} >> i_amount;
        asr_in      = {i_source, 1'b0};
        asr_ext     = asr_in >>> i_amount;
        ror_res     = ror32(i_source, i_amount[4:0]);
        amount_zero = (i_amount == 8'd0);
        rot_zero    = (i_amount[4:0] == 5'd0);

        case (i_shift_type)
            SH_LSL: begin
                o_result        = lsl_ext[31:0];
                o_carry         = lsl_ext[32];
                o_use_old_carry = amount_zero;
            end
            SH_LSR: begin
                o_result        = lsr_ext[32:1];
                o_carry         = lsr_ext[0];
                o_use_old_carry = amount_zero;
            end
            SH_ASR: begin
                o_result        = asr_ext[32:1];
                o_carry         = asr_ext[0];
                o_use_old_carry = amount_zero;
            end
            SH_ROR: begin
                // The last bit rotated out always lands in bit 31.
                o_result        = ror_res;
                o_carry         = ror_res[31];
                o_use_old_carry = amount_zero;
            end
            SH_RORI: begin
                o_result        = ror_res;
                o_carry         = ror_res[31];
                o_use_old_carry = rot_zero;
            end
            default: begin
                o_result        = i_source;
                o_carry         = 1'b0;
                o_use_old_carry = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/zap_shift_arbiter.sv
// ---------------------------------------------------------------------------
// zap_shift_arbiter
//   Shares one zap_shift_shifter between the ALU operand path (port 0) and
//   the load/store register-offset path (port 1). One request is accepted
//   per cycle, shifted combinationally, carry-resolved and captured into a
//   one-entry output stage with valid/ready backpressure.
//   Port 0 wins ties unless port 1 has lost STARVE_LIMIT consecutive ties.
//   Ports:
//     i_clk    clock, all state on the rising edge
//     i_reset  synchronous active-high reset
//     i_flush  drops the output entry and clears the starvation counter
//     bus      zap_shift_arbiter_if.slave (requests, grants, result entry)
// ---------------------------------------------------------------------------
module zap_shift_arbiter
    import zap_shift_arbiter_pkg::*;
#(
    parameter int SHIFT_OPS    = 5,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_flush,
    zap_shift_arbiter_if.slave       bus
);

    localparam int          TW         = $clog2(SHIFT_OPS);
    localparam logic [3:0]  STARVE_MAX = 4'(STARVE_LIMIT);

    state_e     state_q, state_d;
    logic [3:0] starve_cnt_q, starve_cnt_d;
    out_entry_t entry_q, entry_d;

    logic slot_free;
    logic can_grant;
    logic starve_force;
    logic grant_1;
    logic ready_0;
    logic ready_1;
    logic accept_0;
    logic accept_1;
    logic accept;

    logic [31:0]   sh_source;
    logic [7:0]    sh_amount;
    logic [TW-1:0] sh_type;
    logic          sel_carry;
    logic [31:0]   sh_result;
    logic          sh_carry;
    logic          sh_use_old;
    logic          resolved_carry;

    // ------------------------------------------------------------------
    // Arbitration. Readies depend only on slot, flush, reset and starve
    // state, plus the valids for the tie-break, so at most one is high.
    // ------------------------------------------------------------------
    always_comb begin
        slot_free    = (state_q == ST_EMPTY) || bus.i_out_ready;
        can_grant    = slot_free && !i_flush && !i_reset;
        starve_force = (starve_cnt_q == STARVE_MAX);
        grant_1      = bus.i_valid_1 && (!bus.i_valid_0 || starve_force);
        ready_0      = can_grant && !grant_1;
        ready_1      = can_grant && grant_1;
        accept_0     = ready_0 && bus.i_valid_0;
        accept_1     = ready_1 && bus.i_valid_1;
        accept       = accept_0 || accept_1;
    end

    assign bus.o_ready_0 = ready_0;
    assign bus.o_ready_1 = ready_1;

    // ------------------------------------------------------------------
    // Shifter operand mux; port 0 drives the shifter when nothing is
    // granted to port 1.
    // ------------------------------------------------------------------
    always_comb begin
        if (ready_1) begin
            sh_source = bus.i_source_1;
            sh_amount = bus.i_amount_1;
            sh_type   = bus.i_shift_type_1;
            sel_carry = bus.i_carry_1;
        end else begin
            sh_source = bus.i_source_0;
            sh_amount = bus.i_amount_0;
            sh_type   = bus.i_shift_type_0;
            sel_carry = bus.i_carry_0;
        end
    end

    zap_shift_shifter #(
        .SHIFT_OPS (SHIFT_OPS)
    ) u_shifter (
        .i_source        (sh_source),
        .i_amount        (sh_amount),
        .i_shift_type    (sh_type),
        .o_result        (sh_result),
        .o_carry         (sh_carry),
        .o_use_old_carry (sh_use_old)
    );

    assign resolved_carry = sh_use_old ? sel_carry : sh_carry;

    // ------------------------------------------------------------------
    // Next state: starvation counter, output-stage FSM and payload.
    // ------------------------------------------------------------------
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        state_d      = state_q;
        entry_d      = entry_q;

        // Count only ties lost by port 1; a grant to it resets the streak.
        if (i_flush || accept_1) begin
            starve_cnt_d = 4'd0;
        end else if (accept_0 && bus.i_valid_1 && !starve_force) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end

        case (state_q)
            ST_EMPTY: if (accept) state_d = ST_FULL;
            ST_FULL:  if (bus.i_out_ready && !accept) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase

        if (accept) begin
            entry_d.tag    = ready_1 ? TAG_LSU : TAG_ALU;
            entry_d.result = sh_result;
            entry_d.carry  = resolved_carry;
        end

        // Flush wins over drain/refill; any accept is already blocked.
        if (i_flush) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge i_clk) begin
        // NOTE: state updates use non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (i_reset) begin
            state_q      <= ST_EMPTY;
            starve_cnt_q <= 4'd0;
            // NOTE: the payload register is reset as well because its value
            // is visible on o_result/o_tag/o_carry straight after reset.
            entry_q      <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            entry_q      <= entry_d;
        end
    end

    assign bus.o_valid  = (state_q == ST_FULL);
    assign bus.o_tag    = entry_q.tag;
    assign bus.o_result = entry_q.result;
    assign bus.o_carry  = entry_q.carry;

endmodule

// File: tb/tb_zap_shift_arbiter.sv
// ---------------------------------------------------------------------------
// tb_zap_shift_arbiter
//   Directed bench for zap_shift_arbiter with hand-computed expectations:
//   reset values, single requests on both ports across shift types and
//   amount corner cases, starvation-driven grant sequence, backpressure,
//   flush while stalled and reset while full.
// ---------------------------------------------------------------------------
module tb_zap_shift_arbiter;
    import zap_shift_arbiter_pkg::*;

    localparam int SHIFT_OPS    = 5;
    localparam int STARVE_LIMIT = 4;

    localparam logic [2:0] T_LSL  = 3'(LSL);
    localparam logic [2:0] T_LSR  = 3'(LSR);
    localparam logic [2:0] T_ASR  = 3'(ASR);
    localparam logic [2:0] T_ROR  = 3'(ROR);
    localparam logic [2:0] T_RORI = 3'(RORI);

    logic i_clk;
    logic i_reset;
    logic i_flush;

    zap_shift_arbiter_if #(.SHIFT_OPS(SHIFT_OPS)) bus ();

    zap_shift_arbiter #(
        .SHIFT_OPS    (SHIFT_OPS),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_flush (i_flush),
        .bus     (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int          port;
        logic [2:0]  ty;
        logic [31:0] src;
        logic [7:0]  amt;
        logic        cin;
        logic [31:0] res;
        logic        cout;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_req(input int port, input logic [2:0] ty, input logic [31:0] src,
                           input logic [7:0] amt, input logic cin);
        if (port == 0) begin
            bus.i_valid_0      = 1'b1;
            bus.i_shift_type_0 = ty;
            bus.i_source_0     = src;
            bus.i_amount_0     = amt;
            bus.i_carry_0      = cin;
        end else begin
            bus.i_valid_1      = 1'b1;
            bus.i_shift_type_1 = ty;
            bus.i_source_1     = src;
            bus.i_amount_1     = amt;
            bus.i_carry_1      = cin;
        end
    endtask

    task automatic check_entry(input string tag, input logic tg, input logic [31:0] res,
                               input logic c);
        check({tag, "_valid"},  32'(bus.o_valid), 32'd1);
        check({tag, "_tag"},    32'(bus.o_tag),   32'(tg));
        check({tag, "_result"}, bus.o_result,     res);
        check({tag, "_carry"},  32'(bus.o_carry), 32'(c));
    endtask

    int exp_g[10];
    int peak;

    initial begin
        vecs[0] = '{0, T_LSL,  32'h0000_0001, 8'd4,  1'b0, 32'h0000_0010, 1'b0};
        vecs[1] = '{1, T_LSR,  32'h8000_0001, 8'd0,  1'b1, 32'h8000_0001, 1'b1};
        vecs[2] = '{0, T_ASR,  32'h8000_0018, 8'd4,  1'b0, 32'hF800_0001, 1'b1};
        vecs[3] = '{1, T_LSL,  32'h0000_0001, 8'd32, 1'b0, 32'h0000_0000, 1'b1};
        vecs[4] = '{0, T_LSR,  32'hFFFF_FFFF, 8'd33, 1'b1, 32'h0000_0000, 1'b0};
        vecs[5] = '{1, T_ROR,  32'h8000_0000, 8'd32, 1'b0, 32'h8000_0000, 1'b1};
        vecs[6] = '{0, T_RORI, 32'h8000_0000, 8'd32, 1'b0, 32'h8000_0000, 1'b0};
        vecs[7] = '{1, T_ROR,  32'h0000_000F, 8'd4,  1'b0, 32'hF000_0000, 1'b1};
        vecs[8] = '{0, T_ASR,  32'h4000_0000, 8'd40, 1'b1, 32'h0000_0000, 1'b0};
        vecs[9] = '{1, T_LSL,  32'h8000_0003, 8'd1,  1'b0, 32'h0000_0006, 1'b1};
        exp_g   = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

        // ---------------- reset ----------------
        i_reset            = 1'b1;
        i_flush            = 1'b0;
        bus.i_out_ready    = 1'b1;
        bus.i_valid_1      = 1'b0;
        bus.i_source_1     = '0;
        bus.i_amount_1     = '0;
        bus.i_shift_type_1 = '0;
        bus.i_carry_1      = 1'b0;
        set_req(0, T_LSL, 32'h1, 8'd4, 1'b0);
        tick();
        tick();
        check("rst_ready0", 32'(bus.o_ready_0), 32'd0);
        check("rst_ready1", 32'(bus.o_ready_1), 32'd0);
        check("rst_valid",  32'(bus.o_valid),   32'd0);
        check("rst_tag",    32'(bus.o_tag),     32'd0);
        check("rst_result", bus.o_result,       32'h0);
        check("rst_carry",  32'(bus.o_carry),   32'd0);
        check("rst_starve", 32'(dut.starve_cnt_q), 32'd0);
        bus.i_valid_0 = 1'b0;
        i_reset       = 1'b0;
        tick();

        // ---------------- single requests ----------------
        foreach (vecs[i]) begin
            set_req(vecs[i].port, vecs[i].ty, vecs[i].src, vecs[i].amt, vecs[i].cin);
            bus.i_out_ready = 1'b1;
            #1;
            if (vecs[i].port == 0)
                check($sformatf("v%0d_ready0", i), 32'(bus.o_ready_0), 32'd1);
            else
                check($sformatf("v%0d_ready1", i), 32'(bus.o_ready_1), 32'd1);
            tick();
            bus.i_valid_0 = 1'b0;
            bus.i_valid_1 = 1'b0;
            check_entry($sformatf("v%0d", i), vecs[i].port[0], vecs[i].res, vecs[i].cout);
            tick();
            check($sformatf("v%0d_drained", i), 32'(bus.o_valid), 32'd0);
        end

        // ---------------- starvation ----------------
        set_req(0, T_LSL, 32'h1, 8'd1, 1'b0);   // result 0x2
        set_req(1, T_LSL, 32'h1, 8'd2, 1'b0);   // result 0x4
        bus.i_out_ready = 1'b1;
        peak = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            check($sformatf("starve%0d_ready1", i), 32'(bus.o_ready_1), 32'(exp_g[i]));
            check($sformatf("starve%0d_ready0", i), 32'(bus.o_ready_0), 32'(1 - exp_g[i]));
            tick();
            check($sformatf("starve%0d_tag", i), 32'(bus.o_tag), 32'(exp_g[i]));
            check($sformatf("starve%0d_result", i), bus.o_result,
                  (exp_g[i] == 1) ? 32'h4 : 32'h2);
            if (int'(dut.starve_cnt_q) > peak) peak = int'(dut.starve_cnt_q);
        end
        check("starve_peak", 32'(peak), 32'd4);
        bus.i_valid_0 = 1'b0;
        bus.i_valid_1 = 1'b0;
        tick();

        // ---------------- backpressure ----------------
        set_req(0, T_ROR, 32'h0000_000F, 8'd4, 1'b0);
        #1;
        check("bp_ready0", 32'(bus.o_ready_0), 32'd1);
        tick();
        bus.i_valid_0   = 1'b0;
        bus.i_out_ready = 1'b0;
        set_req(1, T_LSR, 32'h0000_0100, 8'd4, 1'b0);   // result 0x10, carry 0
        check_entry("bp_load", 1'b0, 32'hF000_0000, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("bp%0d_ready0", i), 32'(bus.o_ready_0), 32'd0);
            check($sformatf("bp%0d_ready1", i), 32'(bus.o_ready_1), 32'd0);
            tick();
            check_entry($sformatf("bp%0d", i), 1'b0, 32'hF000_0000, 1'b1);
        end
        bus.i_out_ready = 1'b1;
        #1;
        check("bp_release_ready1", 32'(bus.o_ready_1), 32'd1);
        tick();
        bus.i_valid_1 = 1'b0;
        check_entry("bp_refill", 1'b1, 32'h0000_0010, 1'b0);

        // ---------------- flush while stalled ----------------
        set_req(0, T_LSL, 32'h1, 8'd1, 1'b0);
        set_req(1, T_LSR, 32'h0000_0100, 8'd4, 1'b0);
        tick();
        tick();
        check("fl_starve_pre", 32'(dut.starve_cnt_q), 32'd2);
        check("fl_tag_pre", 32'(bus.o_tag), 32'd0);
        bus.i_valid_0   = 1'b0;
        bus.i_out_ready = 1'b0;
        tick();
        i_flush = 1'b1;
        #1;
        check("fl_ready0", 32'(bus.o_ready_0), 32'd0);
        check("fl_ready1", 32'(bus.o_ready_1), 32'd0);
        tick();
        i_flush = 1'b0;
        check("fl_valid",  32'(bus.o_valid), 32'd0);
        check("fl_starve", 32'(dut.starve_cnt_q), 32'd0);
        #1;
        check("fl_after_ready1", 32'(bus.o_ready_1), 32'd1);
        tick();
        bus.i_valid_1 = 1'b0;
        check_entry("fl_after", 1'b1, 32'h0000_0010, 1'b0);

        // ---------------- reset while full ----------------
        set_req(0, T_LSL, 32'h1, 8'd4, 1'b0);
        i_reset = 1'b1;
        #1;
        check("rf_ready0", 32'(bus.o_ready_0), 32'd0);
        tick();
        i_reset = 1'b0;
        check("rf_valid",  32'(bus.o_valid), 32'd0);
        check("rf_result", bus.o_result,     32'h0);
        check("rf_tag",    32'(bus.o_tag),   32'd0);
        check("rf_carry",  32'(bus.o_carry), 32'd0);
        bus.i_out_ready = 1'b1;
        #1;
        check("rf_first_ready0", 32'(bus.o_ready_0), 32'd1);
        tick();
        bus.i_valid_0 = 1'b0;
        check_entry("rf_first", 1'b0, 32'h0000_0010, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
